// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: tracks the outstanding data-SRAM response, buffers it across WB stalls,
// and counts responses owed to flushed instructions. Define MEM_LOAD_EXT_EN for sub-word loads.
module mem_stage_lsu #(
    parameter int DW    = 32,
    parameter int PC_W  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            es_valid,
    input  logic [PC_W-1:0] es_pc,
    input  logic [DW-1:0]   es_alu_result,
    input  logic            es_res_from_mem,
    input  logic [2:0]      es_ld_op,
    input  logic            es_req_issued,
    input  logic            es_reg_we,
    input  logic [RA_W-1:0] es_reg_waddr,
    output logic            ms_allow_in,
    input  logic            ws_allow_in,
    output logic            ms_to_ws_valid,
    output logic [PC_W-1:0] ms_pc,
    output logic [DW-1:0]   ms_final_result,
    output logic            ms_reg_we,
    output logic [RA_W-1:0] ms_reg_waddr,
    output logic            ms_byp_we,
    output logic [RA_W-1:0] ms_byp_waddr,
    output logic [DW-1:0]   ms_byp_wdata,
    output logic            ms_byp_stall,
    input  logic            flush,
    input  logic            data_sram_data_ok,
    input  logic [DW-1:0]   data_sram_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            ms_valid;
    logic            ms_wait;
    logic            buf_valid;
    logic [DW-1:0]   buf_data;
    logic [CNT_W-1:0] cancel_cnt;

    logic [PC_W-1:0] pl_pc;
    logic [DW-1:0]   pl_alu_result;
    logic            pl_res_from_mem;
    logic            pl_reg_we;
    logic [RA_W-1:0] pl_reg_waddr;

    logic            cnt_zero;
    logic            resp_drop;
    logic            resp_mem;
    logic            ms_ready_go;
    logic            load_in;
    logic            kill_mem;
    logic            kill_exe;
    logic [CNT_W:0]  cnt_sum;
    logic [CNT_W-1:0] cnt_next;
    logic [DW-1:0]   raw_data;
    logic [DW-1:0]   load_data;

    // A response goes to MEM only once every cancelled response ahead of it has drained.
    assign cnt_zero    = (cancel_cnt == '0);
    assign resp_drop   = data_sram_data_ok && !cnt_zero;
    assign resp_mem    = data_sram_data_ok && cnt_zero && ms_valid && ms_wait && !buf_valid;
    assign ms_ready_go = !ms_wait || buf_valid || (data_sram_data_ok && cnt_zero);

    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign load_in        = ms_allow_in && es_valid && !flush;

    assign kill_mem = ms_valid && ms_wait && !buf_valid && !resp_mem;
    assign kill_exe = es_valid && es_req_issued;

    always_comb begin
        cnt_sum = {1'b0, cancel_cnt};
        if (resp_drop)
            cnt_sum = cnt_sum - (CNT_W+1)'(1);
        if (flush)
            cnt_sum = cnt_sum + (CNT_W+1)'(kill_mem) + (CNT_W+1)'(kill_exe);
        cnt_next = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    assign raw_data = buf_valid ? buf_data : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
    localparam int OFF_W = $clog2(DW / 8);
    localparam int IDX_W = $clog2(DW);

    logic [2:0]       pl_ld_op;
    logic [OFF_W-1:0] lane_off;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] half_idx;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    always_ff @(posedge clk) begin
        if (load_in)
            pl_ld_op <= es_ld_op;
    end

    assign lane_off = pl_alu_result[OFF_W-1:0];
    assign byte_idx = {lane_off, 3'b000};
    assign half_idx = {lane_off[OFF_W-1:1], 4'b0000};
    assign byte_v   = raw_data[byte_idx +: 8];
    assign half_v   = raw_data[half_idx +: 16];

    always_comb begin
        case (pl_ld_op)
            3'b001:  load_data = {{(DW-8){byte_v[7]}}, byte_v};
            3'b010:  load_data = {{(DW-8){1'b0}}, byte_v};
            3'b011:  load_data = {{(DW-16){half_v[15]}}, half_v};
            3'b100:  load_data = {{(DW-16){1'b0}}, half_v};
            default: load_data = raw_data;
        endcase
    end
`else
    logic ld_op_unused;
    assign ld_op_unused = ^es_ld_op;
    assign load_data    = raw_data;
`endif

    assign ms_final_result = pl_res_from_mem ? load_data : pl_alu_result;
    assign ms_pc           = pl_pc;
    assign ms_reg_we       = ms_valid && pl_reg_we;
    assign ms_reg_waddr    = pl_reg_waddr;
    assign ms_byp_we       = ms_valid && pl_reg_we;
    assign ms_byp_waddr    = pl_reg_waddr;
    assign ms_byp_wdata    = ms_final_result;
    assign ms_byp_stall    = ms_valid && pl_res_from_mem && !ms_ready_go;

    // Control state; the buffer only fills when the response arrives but the instruction cannot leave.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            ms_wait    <= 1'b0;
            buf_valid  <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            cancel_cnt <= cnt_next;
            if (flush) begin
                ms_valid  <= 1'b0;
                ms_wait   <= 1'b0;
                buf_valid <= 1'b0;
            end else if (ms_allow_in) begin
                ms_valid  <= es_valid;
                ms_wait   <= es_valid && es_req_issued;
                buf_valid <= 1'b0;
            end else if (resp_mem) begin
                buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_in) begin
            pl_pc           <= es_pc;
            pl_alu_result   <= es_alu_result;
            pl_res_from_mem <= es_res_from_mem;
            pl_reg_we       <= es_reg_we;
            pl_reg_waddr    <= es_reg_waddr;
        end
        if (!flush && !ms_allow_in && resp_mem)
            buf_data <= data_sram_rdata;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the stage (DW=32).
module tb_mem_stage_lsu;

    localparam int DW = 32, PC_W = 32, RA_W = 5, CNT_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            es_valid;
    logic [PC_W-1:0] es_pc;
    logic [DW-1:0]   es_alu_result;
    logic            es_res_from_mem;
    logic [2:0]      es_ld_op;
    logic            es_req_issued;
    logic            es_reg_we;
    logic [RA_W-1:0] es_reg_waddr;
    logic            ms_allow_in;
    logic            ws_allow_in;
    logic            ms_to_ws_valid;
    logic [PC_W-1:0] ms_pc;
    logic [DW-1:0]   ms_final_result;
    logic            ms_reg_we;
    logic [RA_W-1:0] ms_reg_waddr;
    logic            ms_byp_we;
    logic [RA_W-1:0] ms_byp_waddr;
    logic [DW-1:0]   ms_byp_wdata;
    logic            ms_byp_stall;
    logic            flush;
    logic            data_sram_data_ok;
    logic [DW-1:0]   data_sram_rdata;

    mem_stage_lsu #(.DW(DW), .PC_W(PC_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .es_valid(es_valid), .es_pc(es_pc), .es_alu_result(es_alu_result),
        .es_res_from_mem(es_res_from_mem), .es_ld_op(es_ld_op), .es_req_issued(es_req_issued),
        .es_reg_we(es_reg_we), .es_reg_waddr(es_reg_waddr),
        .ms_allow_in(ms_allow_in), .ws_allow_in(ws_allow_in), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_reg_we(ms_reg_we),
        .ms_reg_waddr(ms_reg_waddr), .ms_byp_we(ms_byp_we), .ms_byp_waddr(ms_byp_waddr),
        .ms_byp_wdata(ms_byp_wdata), .ms_byp_stall(ms_byp_stall), .flush(flush),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model of the instruction sitting in MEM and of responses owed to killed instructions.
    logic        m_valid = 1'b0, m_load = 1'b0, m_wait = 1'b0, m_got = 1'b0, m_we = 1'b0;
    logic [2:0]  m_op;
    logic [31:0] m_pc, m_addr, m_data;
    logic [4:0]  m_waddr;
    int          m_cancel = 0;
    logic        expAllow, respToMem;
    logic        esTaken = 1'b1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                                 input logic ld, input logic [2:0] op, input logic req,
                                 input logic we, input logic [4:0] wa);
        es_valid = v; es_pc = pc; es_alu_result = addr; es_res_from_mem = ld;
        es_ld_op = op; es_req_issued = req; es_reg_we = we; es_reg_waddr = wa;
    endtask

    function automatic logic [31:0] expLoad(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] raw);
`ifdef MEM_LOAD_EXT_EN
        int unsigned off, b, h;
        off = addr % 4;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return h;
            default: return raw;
        endcase
`else
        if (op == 3'd7 && addr == 32'hFFFF_FFFF) return raw;
        return raw;
`endif
    endfunction

    // Predict this cycle's outputs and compare them on the falling edge.
    task automatic checkCycle();
        logic        ready;
        logic [31:0] raw, res;
        @(negedge clk);
        respToMem = data_sram_data_ok && m_cancel == 0 && m_valid && m_wait && !m_got;
        ready     = !m_wait || m_got || respToMem;
        raw       = m_got ? m_data : data_sram_rdata;
        res       = m_load ? expLoad(m_op, m_addr, raw) : m_addr;
        expAllow  = !m_valid || (ready && ws_allow_in);
        if (!reset) begin
            checkOutput("allow_in", ms_allow_in, expAllow);
            checkOutput("to_ws_valid", ms_to_ws_valid, m_valid && ready);
            checkOutput("reg_we", ms_reg_we, m_valid && m_we);
            checkOutput("byp_we", ms_byp_we, m_valid && m_we);
            checkOutput("byp_stall", ms_byp_stall, m_valid && m_load && !ready);
            if (m_valid && ready) begin
                checkOutput("final_result", ms_final_result, res);
                checkOutput("byp_wdata", ms_byp_wdata, res);
                checkOutput("pc", ms_pc, m_pc);
                checkOutput("reg_waddr", ms_reg_waddr, m_waddr);
            end
        end
    endtask

    // Advance the model by one rising edge using the inputs held during the cycle.
    task automatic advance();
        int kill;
        @(posedge clk);
        esTaken = flush || !es_valid || expAllow;
        if (reset) begin
            m_valid = 0; m_wait = 0; m_got = 0; m_cancel = 0;
        end else begin
            kill = flush ? int'(m_valid && m_wait && !m_got && !respToMem)
                           + int'(es_valid && es_req_issued) : 0;
            m_cancel = m_cancel - int'(data_sram_data_ok && m_cancel > 0) + kill;
            if (m_cancel > 3) m_cancel = 3;
            if (flush) begin
                m_valid = 0; m_wait = 0; m_got = 0;
            end else if (expAllow) begin
                m_valid = es_valid;
                m_wait  = es_valid && es_req_issued;
                m_got   = 0;
                if (es_valid) begin
                    m_pc = es_pc; m_addr = es_alu_result; m_load = es_res_from_mem;
                    m_op = es_ld_op; m_we = es_reg_we; m_waddr = es_reg_waddr;
                end
            end else if (respToMem) begin
                m_got = 1; m_data = data_sram_rdata;
            end
        end
        #1;
    endtask

    task automatic cycle();
        checkCycle();
        advance();
    endtask

    logic [2:0]  t3Op   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] t3Addr [4] = '{32'h200, 32'h201, 32'h200, 32'h202};
`ifdef MEM_LOAD_EXT_EN
    logic [31:0] t3Exp  [4] = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_1234};
`else
    logic [31:0] t3Exp  [4] = '{32'h1234_80F0, 32'h1234_80F0, 32'h1234_80F0, 32'h1234_80F0};
`endif

    initial begin
        reset = 1; flush = 0; ws_allow_in = 1; data_sram_data_ok = 0; data_sram_rdata = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        reset = 0;
        checkCycle();
        checkOutput("rst_allow_in", ms_allow_in, 1);
        checkOutput("rst_to_ws", ms_to_ws_valid, 0);
        checkOutput("rst_byp_we", ms_byp_we, 0);
        checkOutput("rst_byp_stall", ms_byp_stall, 0);
        advance();

        $display("[TB] full-width load with three-cycle response");
        applyStimulus(1, 32'h1000, 32'h40, 1, 3'd0, 1, 1, 5'd3);
        cycle();
        es_valid = 0;
        checkCycle(); checkOutput("t1_stall1", ms_byp_stall, 1); advance();
        checkCycle(); checkOutput("t1_stall2", ms_byp_stall, 1); advance();
        data_sram_data_ok = 1; data_sram_rdata = 32'h8000_00F0;
        checkCycle();
        checkOutput("t1_valid", ms_to_ws_valid, 1);
        checkOutput("t1_result", ms_final_result, 32'h8000_00F0);
        advance();
        data_sram_data_ok = 0;

        $display("[TB] response buffered across WB stall");
        applyStimulus(1, 32'h1004, 32'h44, 1, 3'd0, 1, 1, 5'd4);
        cycle();
        es_valid = 0; ws_allow_in = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_80F0;
        checkCycle(); checkOutput("t2_allow_hold", ms_allow_in, 0); advance();
        data_sram_data_ok = 0; data_sram_rdata = 32'hDEAD_BEEF;
        checkCycle(); checkOutput("t2_buf_valid", ms_to_ws_valid, 1); advance();
        ws_allow_in = 1;
        checkCycle();
        checkOutput("t2_buf_result", ms_final_result, 32'h1234_80F0);
        checkOutput("t2_allow_release", ms_allow_in, 1);
        advance();

        $display("[TB] sub-word load lanes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h1100 + 32'(i), t3Addr[i], 1, t3Op[i], 1, 1, 5'd9);
            cycle();
            es_valid = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_80F0;
            checkCycle(); checkOutput("t3_ext", ms_final_result, t3Exp[i]); advance();
            data_sram_data_ok = 0;
        end

        $display("[TB] flush with MEM waiting and EXE request issued");
        applyStimulus(1, 32'h2000, 32'h300, 1, 3'd0, 1, 1, 5'd6);
        cycle();
        applyStimulus(1, 32'h2004, 32'h304, 1, 3'd0, 1, 1, 5'd6);
        flush = 1;
        cycle();
        flush = 0;
        checkOutput("t4_cancel_cnt", dut.cancel_cnt, 2);
        applyStimulus(1, 32'h2008, 32'h308, 1, 3'd0, 1, 1, 5'd7);
        data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA_0001;
        cycle();
        es_valid = 0; data_sram_rdata = 32'hAAAA_0002;
        checkCycle(); checkOutput("t4_drop2", ms_to_ws_valid, 0); advance();
        data_sram_rdata = 32'hC0DE_0003;
        checkCycle();
        checkOutput("t4_third_valid", ms_to_ws_valid, 1);
        checkOutput("t4_third_result", ms_final_result, 32'hC0DE_0003);
        checkOutput("t4_third_pc", ms_pc, 32'h2008);
        advance();
        data_sram_data_ok = 0;

        $display("[TB] store waits for data_ok");
        applyStimulus(1, 32'h3000, 32'h100, 0, 3'd0, 1, 0, 5'd0);
        cycle();
        es_valid = 0;
        checkCycle(); checkOutput("t5_wait", ms_to_ws_valid, 0); advance();
        data_sram_data_ok = 1; data_sram_rdata = 32'h5555_5555;
        checkCycle();
        checkOutput("t5_result", ms_final_result, 32'h100);
        checkOutput("t5_reg_we", ms_reg_we, 0);
        advance();
        data_sram_data_ok = 0;

        $display("[TB] reset during wait");
        applyStimulus(1, 32'h4000, 32'h400, 1, 3'd0, 1, 1, 5'd2);
        cycle();
        applyStimulus(1, 32'h4004, 32'h404, 1, 3'd0, 1, 1, 5'd2);
        flush = 1;
        cycle();
        flush = 0;
        applyStimulus(1, 32'h4008, 32'h408, 1, 3'd0, 1, 1, 5'd2);
        cycle();
        es_valid = 0; reset = 1;
        cycle();
        reset = 0;
        checkCycle();
        checkOutput("t6_allow_in", ms_allow_in, 1);
        checkOutput("t6_ms_valid", dut.ms_valid, 0);
        checkOutput("t6_cancel_cnt", dut.cancel_cnt, 0);
        advance();

        $display("[TB] randomized traffic");
        esTaken = 1;
        for (int n = 0; n < 3000; n++) begin
            int kind, inc, nextCnt;
            logic predResp;
            if (esTaken) begin
                kind = $urandom_range(0, 2);
                applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom, kind == 1,
                              3'($urandom_range(0, 4)), kind != 0,
                              kind == 2 ? 1'b0 : 1'($urandom_range(0, 1)),
                              5'($urandom_range(0, 31)));
            end
            ws_allow_in = $urandom_range(0, 3) != 0;
            data_sram_rdata = $urandom;
            data_sram_data_ok = (m_cancel > 0 || (m_valid && m_wait && !m_got))
                                && $urandom_range(0, 1) == 1;
            predResp = data_sram_data_ok && m_cancel == 0 && m_valid && m_wait && !m_got;
            inc = int'(m_valid && m_wait && !m_got && !predResp) + int'(es_valid && es_req_issued);
            nextCnt = m_cancel - int'(data_sram_data_ok && m_cancel > 0) + inc;
            flush = ($urandom_range(0, 15) == 0) && nextCnt <= 2;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access pipeline stage between EXE and WB. It tracks each load or store request that EXE has already issued to the data SRAM and waits a variable number of cycles for its `data_ok` response. A response that arrives while WB is stalled is held in a one-entry buffer. Load data is lane-aligned and sign- or zero-extended. On a pipeline flush, responses still owed to killed instructions are counted and discarded.

## Interface
Parameters:
- `DW`, default 32: data and address-result width; legal values 32 or 64.
- `PC_W`, default 32: PC width.
- `RA_W`, default 5: register address width.
- `CNT_W`, default 2: width of the cancelled-response counter.

Ports (reset `reset`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `es_valid`  in  1  EXE has a valid instruction for MEM
- `es_pc`  in  PC_W  instruction PC
- `es_alu_result`  in  DW  ALU result / memory address
- `es_res_from_mem`  in  1  instruction is a load
- `es_ld_op`  in  3  load type: 000 full width, 001 lb, 010 lbu, 011 lh, 100 lhu
- `es_req_issued`  in  1  EXE's SRAM request was accepted (addr_ok seen)
- `es_reg_we`  in  1  register write enable
- `es_reg_waddr`  in  RA_W  destination register
- `ms_allow_in`  out  1  MEM accepts from EXE this cycle
- `ws_allow_in`  in  1  WB accepts this cycle
- `ms_to_ws_valid`  out  1  valid result toward WB
- `ms_pc`  out  PC_W  PC toward WB
- `ms_final_result`  out  DW  write-back data
- `ms_reg_we`  out  1  write enable; already gated by `ms_valid`
- `ms_reg_waddr`  out  RA_W  destination register
- `ms_byp_we`, `ms_byp_waddr`, `ms_byp_wdata`  out  1/RA_W/DW  bypass to ID
- `ms_byp_stall`  out  1  MEM holds a load whose data has not returned
- `flush`  in  1  kill MEM contents and any EXE-issued request this cycle
- `data_sram_data_ok`  in  1  in-order response strobe
- `data_sram_rdata`  in  DW  response data

## Operation
- Registers:
  - `ms_valid`
  - payload (pc, alu_result, res_from_mem, ld_op, reg_we, reg_waddr)
  - `ms_wait`: a request is outstanding for this instruction
  - `buf_valid` / `buf_data`
  - `cancel_cnt`
- Load on `ms_allow_in && es_valid && !flush`:
  - payload ← es_*
  - `ms_wait` ← `es_req_issued`
  - `buf_valid` ← 0
- `ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in)`.
- `ms_ready_go = !ms_wait || buf_valid || (data_sram_data_ok && cancel_cnt==0)`.
- Response routing when `data_sram_data_ok` is high:
  - If `cancel_cnt != 0`: decrement it; the response is dropped.
  - Else if `ms_valid && ms_wait`: the response belongs to MEM. If WB does not accept it this cycle, latch `buf_data ← data_sram_rdata` and `buf_valid ← 1`.
  - Else: the response is ignored, which is a protocol violation.
- Raw data = `buf_valid ? buf_data : data_sram_rdata`.
- Lane select:
  - Byte lane = `alu_result[log2(DW/8)-1:0]`.
  - lh/lhu use the halfword at `alu_result[log2(DW/8)-1:1]`.
- Extension: lb/lh sign-extend to DW; lbu/lhu zero-extend; 000 passes the full DW.
- `ms_final_result = res_from_mem ? extended data : alu_result`.
- Stores: `es_req_issued=1`, `res_from_mem=0`. MEM still waits for `data_ok`; the result is `alu_result`.
- Flush, in one cycle:
  - `ms_valid` ← 0; `buf_valid` ← 0.
  - `cancel_cnt` += `(ms_valid && ms_wait && !buf_valid && !data_ok_consumed) + (es_valid && es_req_issued)`.
  - A decrement from a same-cycle dropped response is applied in the same update.
- Saturation: `cancel_cnt` saturates at `2^CNT_W-1`; reaching saturation is a protocol violation.
- Bypass:
  - `ms_byp_we = ms_valid && reg_we`.
  - `ms_byp_wdata = ms_final_result`.
  - `ms_byp_stall = ms_valid && res_from_mem && !ms_ready_go`.

## Timing
- Reset: `ms_valid`, `ms_wait`, `buf_valid` and `cancel_cnt` are 0. Consequently `ms_to_ws_valid=0`, `ms_byp_we=0`, `ms_byp_stall=0` and `ms_allow_in=1`. Payload registers are don't-care.
- Latency:
  - No request: 1 cycle in MEM.
  - Load: `ms_to_ws_valid` rises combinationally in the cycle `data_ok` arrives (minimum 1 cycle). It stays high from the buffer until WB accepts.
- Back-to-back: a new instruction enters in the same cycle the old one leaves.
- Simultaneous cases:
  - `flush` together with `data_ok` for the MEM instruction: the response is consumed and is not counted.
  - `reset` mid-wait: all state clears and `cancel_cnt` returns to 0. Responses still in flight from before reset are the system's responsibility.

## Configuration
- `MEM_LOAD_EXT_EN` defined: lane select and lb/lbu/lh/lhu extension as above.
- `MEM_LOAD_EXT_EN` not defined:
  - `ld_op` is ignored; every load returns the full DW raw data.
  - The lane and extension logic is not synthesised.

## Test plan
- Full-width load, `data_ok` 3 cycles after entry, `ws_allow_in=1` → `ms_byp_stall=1` for 2 cycles; in the 3rd cycle the result is `0x8000_00F0` with `ms_to_ws_valid=1`.
- `data_ok` with rdata `0x1234_80F0` while `ws_allow_in=0` for 2 cycles → buffered; on release WB receives `0x1234_80F0` and `ms_allow_in` rises.
- With the macro defined, rdata `0x1234_80F0`:
  - lb addr[1:0]=0 → `0xFFFF_FFF0`
  - lbu addr[1:0]=1 → `0x0000_0080`
  - lh addr[1:0]=0 → `0xFFFF_80F0`
  - lhu addr[1:0]=2 → `0x0000_1234`
- Flush while MEM waits and EXE holds an issued request → `cancel_cnt=2`. The next two `data_ok` responses are dropped. A new load then completes with the third response.
- Store with `alu_result=0x100` → MEM waits for `data_ok`; it then forwards `0x100` with `ms_reg_we=0`.
- Reset asserted mid-wait → next cycle `ms_valid=0`, `cancel_cnt=0`, `ms_allow_in=1`.
